// File: rtl/hue_sequencer.sv
// hue_sequencer
//   Generates three PWM duty values that walk the hue wheel
//   R -> Y -> G -> C -> B -> M -> R in six linear sectors. In each sector
//   one channel is held at full, one is held at zero and one ramps by
//   INC_DEC_VAL per duty step. A step happens once every INC_DEC_INTERVAL
//   enabled clock cycles. All outputs are registered and drive the
//   pwm_value inputs of three pwm instances directly.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset (overrides enable)
//   enable       advance when high, freeze everything when low
//   reverse      (HUE_SEQUENCER_REVERSE_EN only) walk the wheel backwards
//   r_value      red duty,   0..PWM_INTERVAL
//   g_value      green duty, 0..PWM_INTERVAL
//   b_value      blue duty,  0..PWM_INTERVAL
//   sector       current hue sector, 0..5
//   step_strobe  high for the one cycle after every duty step
//
// Build option
//   HUE_SEQUENCER_REVERSE_EN : adds the reverse input. Without it the
//   sequencer only runs forward.

module hue_sequencer #(
  parameter int PWM_INTERVAL     = 1200,
  parameter int INC_DEC_INTERVAL = 12000,
  parameter int INC_DEC_MAX      = 200,
  localparam int W               = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
`ifdef HUE_SEQUENCER_REVERSE_EN
  input  logic         reverse,
`endif
  output logic [W-1:0] r_value,
  output logic [W-1:0] g_value,
  output logic [W-1:0] b_value,
  output logic [2:0]   sector,
  output logic         step_strobe
);

  localparam int INC_DEC_VAL = PWM_INTERVAL / INC_DEC_MAX;
  localparam int PW = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
  localparam int SW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;

  localparam logic [W-1:0]  FULL     = W'(PWM_INTERVAL);
  localparam logic [W-1:0]  VAL      = W'(INC_DEC_VAL);
  localparam logic [PW-1:0] PRESC_TC = PW'(INC_DEC_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_TC  = SW'(INC_DEC_MAX - 1);

  // Parameter sanity: the full duty must fit the output width exactly
  // (not a power of two) and divide evenly into per-sector steps.
  if ((PWM_INTERVAL % INC_DEC_MAX) != 0) begin : g_bad_ratio
    $error("hue_sequencer: PWM_INTERVAL must be a multiple of INC_DEC_MAX");
  end
  if (PWM_INTERVAL >= (2 ** W)) begin : g_bad_width
    $error("hue_sequencer: PWM_INTERVAL must not be a power of two");
  end

  typedef enum logic [2:0] {
    S0 = 3'd0,  // R full, G up,   B 0
    S1 = 3'd1,  // G full, R down, B 0
    S2 = 3'd2,  // G full, B up,   R 0
    S3 = 3'd3,  // B full, G down, R 0
    S4 = 3'd4,  // B full, R up,   G 0
    S5 = 3'd5   // R full, B down, G 0
  } sector_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  function automatic sector_e sec_next(input sector_e s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      S4:      return S5;
      S5:      return S0;
      default: return S0;
    endcase
  endfunction

  function automatic sector_e sec_prev(input sector_e s);
    case (s)
      S0:      return S5;
      S1:      return S0;
      S2:      return S1;
      S3:      return S2;
      S4:      return S3;
      S5:      return S4;
      default: return S0;
    endcase
  endfunction

  logic rev;
`ifdef HUE_SEQUENCER_REVERSE_EN
  assign rev = reverse;
`else
  assign rev = 1'b0;
`endif

  sector_e       sector_q, sector_d, ramp_sec;
  logic [PW-1:0] presc_q;
  logic [SW-1:0] step_q, step_d;
  logic [W-1:0]  r_q, g_q, b_q;
  logic [W-1:0]  r_d, g_d, b_d;
  logic          strobe_q;
  logic          tc;
  logic          ramp_up;
  chan_e         ramp_ch;

  // step_q is the number of steps already taken inside sector_q, counted
  // in the forward direction. A reverse step is therefore a decrement; a
  // reverse step from count 0 moves into the previous sector at its last
  // count, so the ramping channel backs out of that sector. Because the
  // stored count is position-based, flipping direction mid-sector leaves
  // the values continuous: the count seen by the new direction is the
  // mirror INC_DEC_MAX-1-step of the old one.
  always_comb begin
    tc       = (presc_q == PRESC_TC);
    sector_d = sector_q;
    step_d   = step_q;
    ramp_sec = sector_q;
    ramp_ch  = CH_G;
    ramp_up  = 1'b1;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;

    if (!rev) begin
      if (step_q == STEP_TC) begin
        step_d   = '0;
        sector_d = sec_next(sector_q);
      end else begin
        step_d = step_q + SW'(1);
      end
    end else begin
      if (step_q == '0) begin
        step_d   = STEP_TC;
        sector_d = sec_prev(sector_q);
        ramp_sec = sec_prev(sector_q);
      end else begin
        step_d = step_q - SW'(1);
      end
    end

    case (ramp_sec)
      S0:      begin ramp_ch = CH_G; ramp_up = 1'b1; end
      S1:      begin ramp_ch = CH_R; ramp_up = 1'b0; end
      S2:      begin ramp_ch = CH_B; ramp_up = 1'b1; end
      S3:      begin ramp_ch = CH_G; ramp_up = 1'b0; end
      S4:      begin ramp_ch = CH_R; ramp_up = 1'b1; end
      S5:      begin ramp_ch = CH_B; ramp_up = 1'b0; end
      default: begin ramp_ch = CH_G; ramp_up = 1'b1; end
    endcase

    if (rev) begin
      ramp_up = !ramp_up;
    end

    // The sector structure guarantees the ramp never leaves 0..FULL, so a
    // plain add/subtract at the output width is exact.
    case (ramp_ch)
      CH_R:    r_d = ramp_up ? (r_q + VAL) : (r_q - VAL);
      CH_G:    g_d = ramp_up ? (g_q + VAL) : (g_q - VAL);
      CH_B:    b_d = ramp_up ? (b_q + VAL) : (b_q - VAL);
      default: g_d = g_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      step_q   <= '0;
      sector_q <= S0;
      r_q      <= FULL;
      g_q      <= '0;
      b_q      <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (enable) begin
        if (tc) begin
          presc_q  <= '0;
          step_q   <= step_d;
          sector_q <= sector_d;
          r_q      <= r_d;
          g_q      <= g_d;
          b_q      <= b_d;
          strobe_q <= 1'b1;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  assign r_value     = r_q;
  assign g_value     = g_q;
  assign b_value     = b_q;
  assign sector      = sector_q;
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Testbench for hue_sequencer with a small configuration
// (PWM_INTERVAL=12, INC_DEC_INTERVAL=4, INC_DEC_MAX=4, duty step 3).
// The stimulus thread drives inputs on the falling edge, advances a
// wheel-position reference model and queues the expected outputs after
// the next rising edge. The monitor thread pops one entry per cycle just
// after the rising edge and compares, and also checks wheel invariants.

module tb_hue_sequencer;

  localparam int P_PWM = 12;
  localparam int P_INT = 4;
  localparam int P_MAX = 4;
  localparam int P_VAL = P_PWM / P_MAX;
  localparam int P_N   = 6 * P_MAX;   // positions around the wheel

  logic       clk;
  logic       rst;
  logic       enable;
  logic       reverse_s;
  logic [3:0] r_value;
  logic [3:0] g_value;
  logic [3:0] b_value;
  logic [2:0] sector;
  logic       step_strobe;

  hue_sequencer #(
    .PWM_INTERVAL    (P_PWM),
    .INC_DEC_INTERVAL(P_INT),
    .INC_DEC_MAX     (P_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
`ifdef HUE_SEQUENCER_REVERSE_EN
    .reverse    (reverse_s),
`endif
    .r_value    (r_value),
    .g_value    (g_value),
    .b_value    (b_value),
    .sector     (sector),
    .step_strobe(step_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r;
    int g;
    int b;
    int sec;
    int stb;
    bit rst;
  } exp_t;

  exp_t exp_q[$];

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model state: position on the wheel (sector*MAX + step) and
  // the enabled-cycle count inside the current step.
  int m_p     = 0;
  int m_presc = 0;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Duty values as a direct function of wheel position.
  task automatic hue(input int p, output int r, output int g, output int b);
    int s;
    int f;
    s = p / P_MAX;
    f = (p % P_MAX) * P_VAL;
    case (s)
      0:       begin r = P_PWM;     g = f;         b = 0;         end
      1:       begin r = P_PWM - f; g = P_PWM;     b = 0;         end
      2:       begin r = 0;         g = P_PWM;     b = f;         end
      3:       begin r = 0;         g = P_PWM - f; b = P_PWM;     end
      4:       begin r = f;         g = 0;         b = P_PWM;     end
      default: begin r = P_PWM;     g = 0;         b = P_PWM - f; end
    endcase
  endtask

  task automatic drive(input bit r, input bit e, input bit v);
    exp_t x;
    bit   v_eff;
`ifdef HUE_SEQUENCER_REVERSE_EN
    v_eff = v;
`else
    v_eff = 1'b0;
`endif
    @(negedge clk);
    rst       = r;
    enable    = e;
    reverse_s = v;
    x.stb = 0;
    x.rst = r;
    if (r) begin
      m_p     = 0;
      m_presc = 0;
    end else if (e) begin
      if (m_presc == P_INT - 1) begin
        m_presc = 0;
        m_p     = v_eff ? (m_p + P_N - 1) % P_N : (m_p + 1) % P_N;
        x.stb   = 1;
      end else begin
        m_presc++;
      end
    end
    hue(m_p, x.r, x.g, x.b);
    x.sec = m_p / P_MAX;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per rising edge, compared 1 ns after it.
  initial begin
    exp_t x;
    int   pr, pg, pb;
    bit   have_prev;
    int   nchg;
    bit   mag_ok;
    int   n_full, n_zero;
    have_prev = 0;
    pr = 0; pg = 0; pb = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("r_value", int'(r_value), x.r);
        chk("g_value", int'(g_value), x.g);
        chk("b_value", int'(b_value), x.b);
        chk("sector", int'(sector), x.sec);
        chk("step_strobe", int'(step_strobe), x.stb);

        // Wheel invariants. At a sector boundary the ramping channel sits
        // at 0 or full too, so "at least one" of each is the exact rule.
        n_full = 0;
        n_zero = 0;
        if (int'(r_value) == P_PWM) n_full++;
        if (int'(g_value) == P_PWM) n_full++;
        if (int'(b_value) == P_PWM) n_full++;
        if (r_value == 4'd0) n_zero++;
        if (g_value == 4'd0) n_zero++;
        if (b_value == 4'd0) n_zero++;
        chk("range_ok", int'((int'(r_value) <= P_PWM) && (int'(g_value) <= P_PWM)
                             && (int'(b_value) <= P_PWM)), 1);
        chk("has_full", int'(n_full >= 1), 1);
        chk("has_zero", int'(n_zero >= 1), 1);

        if (have_prev && !x.rst) begin
          nchg   = 0;
          mag_ok = 1;
          if (int'(r_value) != pr) begin
            nchg++;
            if ((int'(r_value) - pr != P_VAL) && (pr - int'(r_value) != P_VAL)) mag_ok = 0;
          end
          if (int'(g_value) != pg) begin
            nchg++;
            if ((int'(g_value) - pg != P_VAL) && (pg - int'(g_value) != P_VAL)) mag_ok = 0;
          end
          if (int'(b_value) != pb) begin
            nchg++;
            if ((int'(b_value) - pb != P_VAL) && (pb - int'(b_value) != P_VAL)) mag_ok = 0;
          end
          chk("chan_changes", nchg, int'(step_strobe));
          chk("change_by_step", int'(mag_ok), 1);
        end
        pr = int'(r_value);
        pg = int'(g_value);
        pb = int'(b_value);
        have_prev = 1;
      end
    end
  end

  initial begin
    bit reached;
    bit rv;
    rst       = 1'b1;
    enable    = 1'b0;
    reverse_s = 1'b0;

    // Reset, then one full forward wheel (96 enabled edges).
    drive(1, 0, 0);
    drive(1, 1, 0);
    for (int i = 0; i < 96; i++) drive(0, 1, 0);

    // Freeze mid-step with the prescaler at 2, then resume.
    drive(0, 1, 0);
    drive(0, 1, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 0);

    // Freeze on the terminal-count cycle: no step may occur.
    reached = 0;
    for (int i = 0; i < 8 && !reached; i++) begin
      if (m_presc == P_INT - 1) reached = 1;
      else drive(0, 1, 0);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0);

    // Reset in sector 4, step 2, partway through a step.
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (m_p == 4 * P_MAX + 2 && m_presc == 2) reached = 1;
      else drive(0, 1, 0);
    end
    chk("reach_s4_step2", int'(reached), 1);
    drive(1, 1, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 0);

`ifdef HUE_SEQUENCER_REVERSE_EN
    // Reverse from reset: first step lands in sector 5 with b=3.
    drive(1, 0, 0);
    for (int i = 0; i < 24; i++) drive(0, 1, 1);
    for (int i = 0; i < 10; i++) drive(0, 1, 0);
`endif

    // Randomised run: several wheels with random freezes, rare resets and
    // (when available) random direction changes.
    rv = 0;
    for (int i = 0; i < 900; i++) begin
`ifdef HUE_SEQUENCER_REVERSE_EN
      if ($urandom_range(0, 29) == 0) rv = ~rv;
`endif
      drive(($urandom_range(0, 249) == 0), ($urandom_range(0, 9) != 0), rv);
    end

    // Let the monitor drain the last expectations.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
